// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte-addressed little-endian data memory with combinational loads
module data_mem #(
    parameter int mem_size = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] Single_Instruction,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic [31:0] loadData_w,
    output logic        LD_memory_avalible,
    output logic        SD_memory_avalible,
    output logic        load_into_reg
);
    localparam int AW = (mem_size > 1) ? $clog2(mem_size) : 1;

    logic [7:0]    r_mem [0:mem_size-1];

    logic [7:0]    w_ops;
    logic          w_one_op;
    logic          w_lb, w_lh, w_lw, w_lbu, w_lhu, w_sb, w_sh, w_sw;
    logic          w_is_load, w_is_store;
    logic          w_byte, w_half, w_word;
    logic [32:0]   w_last;
    logic          w_in_range, w_aligned, w_valid;
    logic [AW-1:0] w_idx0, w_idx1, w_idx2, w_idx3;
    logic [7:0]    w_b0, w_b1, w_b2, w_b3;
    logic          w_unused_bits;

    // Only bits 10-17 carry memory ops; the rest of the instruction vector is ignored.
    assign w_unused_bits = ^{Single_Instruction[63:18], Single_Instruction[9:0]};

    // Decode: exactly one memory op bit set, anything else is treated as no op.
    always_comb begin
        w_ops    = Single_Instruction[17:10];
        w_one_op = (w_ops != 8'd0) && ((w_ops & (w_ops - 8'd1)) == 8'd0);
        w_lb     = w_one_op & w_ops[0];
        w_lh     = w_one_op & w_ops[1];
        w_lw     = w_one_op & w_ops[2];
        w_lbu    = w_one_op & w_ops[3];
        w_lhu    = w_one_op & w_ops[4];
        w_sb     = w_one_op & w_ops[5];
        w_sh     = w_one_op & w_ops[6];
        w_sw     = w_one_op & w_ops[7];
        w_is_load  = w_lb | w_lh | w_lw | w_lbu | w_lhu;
        w_is_store = w_sb | w_sh | w_sw;
        w_byte     = w_lb | w_lbu | w_sb;
        w_half     = w_lh | w_lhu | w_sh;
        w_word     = w_lw | w_sw;
    end

    // Range and alignment; the last byte is computed in 33 bits so addresses near 2^32 cannot wrap.
    always_comb begin
        w_last = {1'b0, address};
        if (w_half) begin
            w_last = {1'b0, address} + 33'd1;
        end else if (w_word) begin
            w_last = {1'b0, address} + 33'd3;
        end
        w_in_range = (w_last < 33'(mem_size));
        w_aligned  = w_byte
                   | (w_half & ~address[0])
                   | (w_word & (address[1:0] == 2'b00));
        w_valid    = w_in_range & w_aligned;
        LD_memory_avalible = w_is_load & w_valid;
        SD_memory_avalible = w_is_store & w_valid;
        load_into_reg      = w_is_load & w_valid;
    end

    // Byte lanes for the addressed word; lanes past the end are only used when the access is invalid.
    always_comb begin
        w_idx0 = address[AW-1:0];
        w_idx1 = w_idx0 + AW'(1);
        w_idx2 = w_idx0 + AW'(2);
        w_idx3 = w_idx0 + AW'(3);
        w_b0   = r_mem[w_idx0];
        w_b1   = r_mem[w_idx1];
        w_b2   = r_mem[w_idx2];
        w_b3   = r_mem[w_idx3];
    end

    // Load extension; output is forced to zero unless the load is valid.
    always_comb begin
        loadData_w = 32'd0;
        if (LD_memory_avalible) begin
            if (w_lb) begin
                loadData_w = {{24{w_b0[7]}}, w_b0};
            end else if (w_lbu) begin
                loadData_w = {24'd0, w_b0};
            end else if (w_lh) begin
                loadData_w = {{16{w_b1[7]}}, w_b1, w_b0};
            end else if (w_lhu) begin
                loadData_w = {16'd0, w_b1, w_b0};
            end else begin
                loadData_w = {w_b3, w_b2, w_b1, w_b0};
            end
        end
    end

    // Storage: reset clears every byte and swallows any store presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < mem_size; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else if (SD_memory_avalible) begin
            r_mem[w_idx0] <= storeData[7:0];
            if (w_half || w_word) begin
                r_mem[w_idx1] <= storeData[15:8];
            end
            if (w_word) begin
                r_mem[w_idx2] <= storeData[23:16];
                r_mem[w_idx3] <= storeData[31:24];
            end
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - table-driven self-checking bench for data_mem
module tb_data_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] si;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] ld_data;
    logic        ld_v, sd_v, ld_reg;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] LB  = 64'd1 << 10;
    localparam logic [63:0] LH  = 64'd1 << 11;
    localparam logic [63:0] LW  = 64'd1 << 12;
    localparam logic [63:0] LBU = 64'd1 << 13;
    localparam logic [63:0] LHU = 64'd1 << 14;
    localparam logic [63:0] SB  = 64'd1 << 15;
    localparam logic [63:0] SH  = 64'd1 << 16;
    localparam logic [63:0] SW  = 64'd1 << 17;

    typedef struct {
        logic [63:0] si;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] exp_ld;
        logic        exp_ldv;
        logic        exp_sdv;
    } vec_t;

    vec_t vecs[$];

    data_mem #(.mem_size(4096)) dut (
        .clk(clk),
        .reset(reset),
        .Single_Instruction(si),
        .address(addr),
        .storeData(sdata),
        .loadData_w(ld_data),
        .LD_memory_avalible(ld_v),
        .SD_memory_avalible(sd_v),
        .load_into_reg(ld_reg)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [63:0] s, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] eld, input logic eldv, input logic esdv);
        vec_t v;
        v.si = s; v.addr = a; v.sdata = d; v.exp_ld = eld; v.exp_ldv = eldv; v.exp_sdv = esdv;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] eld, input logic eldv, input logic esdv);
        check({tag, " loadData_w"}, ld_data, eld);
        check({tag, " LD_avail"}, {31'd0, ld_v}, {31'd0, eldv});
        check({tag, " SD_avail"}, {31'd0, sd_v}, {31'd0, esdv});
        check({tag, " load_into_reg"}, {31'd0, ld_reg}, {31'd0, eldv});
    endtask

    task automatic drive(input logic [63:0] s, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        si = s; addr = a; sdata = d;
        #1;
    endtask

    initial begin
        add(LW,        32'h000,      32'h0,         32'h00000000, 1'b1, 1'b0);
        add(SW,        32'h010,      32'h876543A1,  32'h0,        1'b0, 1'b1);
        add(LW,        32'h010,      32'h0,         32'h876543A1, 1'b1, 1'b0);
        add(LB,        32'h010,      32'h0,         32'hFFFFFFA1, 1'b1, 1'b0);
        add(LBU,       32'h010,      32'h0,         32'h000000A1, 1'b1, 1'b0);
        add(LH,        32'h012,      32'h0,         32'hFFFF8765, 1'b1, 1'b0);
        add(LHU,       32'h012,      32'h0,         32'h00008765, 1'b1, 1'b0);
        add(SB,        32'h011,      32'hAAAAAA55,  32'h0,        1'b0, 1'b1);
        add(LW,        32'h010,      32'h0,         32'h876555A1, 1'b1, 1'b0);
        add(SH,        32'h012,      32'hFFFF1234,  32'h0,        1'b0, 1'b1);
        add(LW,        32'h010,      32'h0,         32'h123455A1, 1'b1, 1'b0);
        add(SW,        32'h011,      32'hFFFFFFFF,  32'h0,        1'b0, 1'b0);
        add(SW,        32'h1000,     32'hFFFFFFFF,  32'h0,        1'b0, 1'b0);
        add(SH,        32'h013,      32'hFFFFFFFF,  32'h0,        1'b0, 1'b0);
        add(LW,        32'h010,      32'h0,         32'h123455A1, 1'b1, 1'b0);
        add(SW,        32'hFFC,      32'hCAFEF00D,  32'h0,        1'b0, 1'b1);
        add(LW,        32'hFFC,      32'h0,         32'hCAFEF00D, 1'b1, 1'b0);
        add(LW,        32'hFFD,      32'h0,         32'h0,        1'b0, 1'b0);
        add(LB,        32'hFFF,      32'h0,         32'hFFFFFFCA, 1'b1, 1'b0);
        add(LH,        32'hFFF,      32'h0,         32'h0,        1'b0, 1'b0);
        add(LH,        32'hFFE,      32'h0,         32'hFFFFCAFE, 1'b1, 1'b0);
        add(LHU,       32'h011,      32'h0,         32'h0,        1'b0, 1'b0);
        add(LW,        32'h00010010, 32'h0,         32'h0,        1'b0, 1'b0);
        add(LW,        32'hFFFFFFFC, 32'h0,         32'h0,        1'b0, 1'b0);
        add(LW | SW,   32'h010,      32'h0,         32'h0,        1'b0, 1'b0);
        add(64'd0,     32'h010,      32'h0,         32'h0,        1'b0, 1'b0);
        add(64'd1 << 9, 32'h010,     32'h0,         32'h0,        1'b0, 1'b0);
        add(LB | (64'd1 << 20), 32'h010, 32'h0,     32'hFFFFFFA1, 1'b1, 1'b0);
        add(LW,        32'h010,      32'h0,         32'h123455A1, 1'b1, 1'b0);

        si = 64'd0; addr = 32'd0; sdata = 32'd0; reset = 1'b1;
        #1;
        check_all("reset idle", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].si, vecs[i].addr, vecs[i].sdata);
            check_all($sformatf("v%0d", i), vecs[i].exp_ld, vecs[i].exp_ldv, vecs[i].exp_sdv);
        end

        // Store at 0x020, then a store presented during reset must not land.
        drive(SW, 32'h020, 32'h11111111);
        drive(LW, 32'h020, 32'h0);
        check_all("pre-reset LW 0x020", 32'h11111111, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        si = SW; addr = 32'h020; sdata = 32'hDEADBEEF;
        @(negedge clk);
        reset = 1'b0;
        si = 64'd0;
        #1;
        check_all("post-reset idle", 32'h0, 1'b0, 1'b0);
        drive(LW, 32'h020, 32'h0);
        check_all("post-reset LW 0x020", 32'h0, 1'b1, 1'b0);
        drive(LW, 32'h010, 32'h0);
        check_all("post-reset LW 0x010", 32'h0, 1'b1, 1'b0);
        drive(LW, 32'hFFC, 32'h0);
        check_all("post-reset LW 0xFFC", 32'h0, 1'b1, 1'b0);

        drive(64'd0, 32'h0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter: mem_size, default 4096, memory capacity in bytes; byte-addressed, little-endian.
REQ-002 Ports: clk  input  1  rising-edge clock; reset and clk are already decided as "reset reset, synchronous, active-high; clock clk".
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 Single_Instruction  input  64  one-hot decoded instruction vector; bit 10 LB, 11 LH, 12 LW, 13 LBU, 14 LHU, 15 SB, 16 SH, 17 SW; all other bits ignored.
REQ-005 address  input  32  byte address (ALU result).
REQ-006 storeData  input  32  store source (rs2 value); low byte/halfword used for SB/SH.
REQ-007 loadData_w  output  32  load result, sign/zero-extended.
REQ-008 LD_memory_avalible  output  1  valid load access this cycle.
REQ-009 SD_memory_avalible  output  1  valid store access this cycle.
REQ-010 load_into_reg  output  1  register write-back takes loadData_w.

Function
REQ-011 Op decode: exactly one of bits 10-17 set selects that op; none set or more than one set is "no op".
REQ-012 Access size: byte for LB/LBU/SB, halfword for LH/LHU/SH, word for LW/SW.
REQ-013 Access valid iff address+size-1 < mem_size and address aligned to size (halfword even, word multiple of 4).
REQ-014 LD_memory_avalible = 1 iff decoded op is a load and access valid; combinational, same cycle.
REQ-015 SD_memory_avalible = 1 iff decoded op is a store and access valid; combinational.
REQ-016 load_into_reg equals LD_memory_avalible.
REQ-017 Read path combinational (asynchronous): loadData_w reflects memory content at address in the same cycle.
REQ-018 LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW returns 4 bytes, byte at address in bits 7:0.
REQ-019 loadData_w = 0 whenever LD_memory_avalible = 0.
REQ-020 Store: on rising clk with SD_memory_avalible = 1 and reset = 0, write size bytes of storeData (little-endian) at address; other bytes unchanged.
REQ-021 Invalid (out-of-range, misaligned, multi-hot) accesses: no memory change, all outputs 0; no exception signalled.
REQ-022 Load after store: store committed at edge N visible to a combinational load in cycle N+1; a load in the same cycle as a store (impossible by REQ-011) not required.
REQ-023 Address bits above those needed for mem_size participate in range check; no wrap-around.

Reset
REQ-024 On rising clk with reset = 1, all mem_size bytes cleared to 0 and any store that cycle suppressed.
REQ-025 Outputs carry no state; with Single_Instruction = 0 all outputs are 0 regardless of reset.
REQ-026 Reset mid-operation: a store presented during a reset cycle never lands; memory reads 0 after reset.

Verification
REQ-027 Reset, then LW at 0x000 -> loadData_w = 0x00000000, LD_memory_avalible = 1, load_into_reg = 1.
REQ-028 SW 0x8765_43A1 at 0x010, next cycle LW 0x010 -> 0x876543A1; LB 0x010 -> 0xFFFFFFA1; LBU 0x010 -> 0x000000A1; LH 0x012 -> 0xFFFF8765; LHU 0x012 -> 0x00008765.
REQ-029 SB 0x55 at 0x011 over the word above, then LW 0x010 -> 0x876555A1; SH 0x1234 at 0x012 -> LW 0x010 = 0x123455A1.
REQ-030 SW at 0x011 (misaligned) and SW at 0x1000 (out of range, mem_size 4096) -> SD_memory_avalible = 0, memory unchanged; LW 0xFFC valid, LW 0xFFD invalid with loadData_w = 0.
REQ-031 Single_Instruction with bits 12 and 17 both set -> all outputs 0, no write; Single_Instruction = 0 -> all outputs 0.
REQ-032 SW 0xDEADBEEF at 0x020 asserted with reset = 1 -> after reset LW 0x020 = 0x00000000.
